// File: rtl/gg_code_loader_if.sv
// Cheat-file download bus (ioctl byte stream plus hold) and the code-slot output bus.
// The slave modport belongs to the loader. The master modport belongs to the downloader/consumer side.
interface gg_code_loader_if;
  logic        cheat_dl;
  logic        ioctl_wr;
  logic [9:0]  ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [37:0] code;
  logic [3:0]  code_count;
  logic        overflow;

  modport master (
    output cheat_dl, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, code, code_count, overflow
  );

  modport slave (
    input  cheat_dl, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, code, code_count, overflow
  );
endinterface

// File: rtl/gg_code_loader.sv
// Parses 8-byte cheat records into single-cycle code pulses. All slots are cleared first, in one pulse per slot.
// Each code is emitted one cycle after byte 7 of its record. ioctl_wait holds the sender during CLEAR and EMIT.
module gg_code_loader #(
  parameter int unsigned MAX_CODES = 9
) (
  input  logic              clk,
  input  logic              reset,
  gg_code_loader_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, EMIT} state_e;

  typedef struct packed {
    logic        enable;
    logic        cmp_en;
    logic [14:0] addr;
    logic [7:0]  compare;
    logic [7:0]  replace;
  } rec_t;

  localparam logic [3:0] LAST_SLOT = 4'(MAX_CODES - 1);

  state_e      state_q, state_d;
  logic        cheat_dl_q, cheat_dl_d;
  logic [3:0]  slot_q, slot_d;
  logic [3:0]  idx_q, idx_d;
  rec_t        rec_q, rec_d;
  logic [3:0]  count_q, count_d;
  logic        ovf_q, ovf_d;

  logic        dl_rise;
  logic [2:0]  wr_pos;
  logic [6:0]  wr_rec;
  logic        wr_in_range;
  logic [37:0] code_c;
  logic        wait_c;

  assign dl_rise     = bus.cheat_dl & ~cheat_dl_q;
  assign wr_pos      = bus.ioctl_addr[2:0];
  assign wr_rec      = bus.ioctl_addr[9:3];
  assign wr_in_range = ({25'd0, wr_rec} < MAX_CODES);

  always_comb begin
    state_d    = state_q;
    cheat_dl_d = bus.cheat_dl;
    slot_d     = slot_q;
    idx_d      = idx_q;
    rec_d      = rec_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    code_c     = '0;
    wait_c     = 1'b0;

    case (state_q)
      IDLE: begin
        rec_d = '0;
        if (dl_rise) begin
          state_d = CLEAR;
          slot_d  = 4'd0;
          count_d = 4'd0;
          ovf_d   = 1'b0;
        end
      end

      CLEAR: begin
        rec_d  = '0;
        wait_c = 1'b1;
        code_c = {1'b1, slot_q, 33'd0};
        slot_d = slot_q + 4'd1;
        if (slot_q == LAST_SLOT) begin
          state_d = bus.cheat_dl ? LOAD : IDLE;
        end
      end

      LOAD: begin
        // A download that ends mid-record drops the partial fields.
        if (!bus.cheat_dl) begin
          state_d = IDLE;
          rec_d   = '0;
        end else if (bus.ioctl_wr) begin
          if (!wr_in_range) begin
            ovf_d = 1'b1;
          end else begin
            case (wr_pos)
              3'd0: begin
                rec_d.enable = bus.ioctl_dout[0];
                rec_d.cmp_en = bus.ioctl_dout[1];
              end
              3'd1: rec_d.addr[14:8] = bus.ioctl_dout[6:0];
              3'd2: rec_d.addr[7:0]  = bus.ioctl_dout;
              3'd3: rec_d.compare    = bus.ioctl_dout;
              3'd4: rec_d.replace    = bus.ioctl_dout;
              3'd7: begin
                idx_d   = wr_rec[3:0];
                state_d = EMIT;
              end
              default: ;
            endcase
          end
        end
      end

      EMIT: begin
        wait_c  = 1'b1;
        code_c  = {1'b1, idx_q, rec_q};
        count_d = idx_q + 4'd1;
        rec_d   = '0;
        state_d = bus.cheat_dl ? LOAD : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cheat_dl_q <= 1'b0;
      slot_q     <= 4'd0;
      idx_q      <= 4'd0;
      rec_q      <= '0;
      count_q    <= 4'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cheat_dl_q <= cheat_dl_d;
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      rec_q      <= rec_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.code       = code_c;
  assign bus.ioctl_wait = wait_c;
  assign bus.code_count = count_q;
  assign bus.overflow   = ovf_q;

endmodule
